mem_mgr_noc_decoder: RTL and testbench
======================================

// Module: mem_mgr_noc_decoder
// PURPOSE
//  Inbound NoC side of the DRAM tile memory manager: accepts 32-bit AXI-stream packets, parses header and address words, issues CPU-bus word requests.
//  Registers header1/data1 for mem_mgr_noc_encoder and holds them stable until that encoder reports the reply sent.
//  Header: [28]=long, [27:25]=code, [24]=pt, [23:21]=src Y, [20:18]=src X, [17:6]=offset ([15:12]=log2 len), [5:3]=dest Y, [2:0]=dest X.
// PARAMETERS
//  XY_SZ        3   bits per X/Y coordinate; HsrcId is 2*XY_SZ
//  MAX_LEN_LOG2 8   largest accepted long-packet log2 word count
// PORTS
//  clk_ctrl            in   1   clock
//  clk_ctrl_rst_low    in   1   reset, asynchronous, active-low
//  HsrcId              in   2*XY_SZ  own tile id {Y,X}
//  stream_in_TVALID    in   1   / TDATA in 32 / TKEEP in 4 (ignored) / TLAST in 1
//  stream_in_TREADY    out  1   decoder accepts word
//  cpu_req_valid       out  1   memory request valid
//  cpu_req_we          out  1   1=write, 0=read
//  cpu_req_addr        out  32  byte address
//  cpu_req_data        out  32  write data
//  cpu_req_ready       in   1   memory accepts request
//  header1             out  32  registered header of current packet
//  data1               out  32  registered address word of current packet
//  rsp_done            in   1   pulse: encoder's final reply beat (TLAST handshake)
//  busy                out  1   state != IDLE
//  err_pulse           out  1   one-cycle protocol error flag
// BEHAVIOUR
//  Reset: state IDLE, header1=data1=0, all outputs 0 (TREADY 0 in reset).
//  Word count N = header1[28] ? 2^header1[15:12] : 1; counter 17 bits; addr step +4/word.
//  IDLE: TREADY=1; on TVALID latch TDATA->header1.
//   dest [5:3],[2:0] != HsrcId, code not in {MPUT 4,MGET 5,MLOAD 6,MSTORE 7}, or long with len>MAX_LEN_LOG2 -> err_pulse, DRAIN (IDLE if TLAST).
//   TLAST on header -> err_pulse, stay IDLE. Else -> ADDR.
//  ADDR: TREADY=1; on TVALID latch data1, addr<=TDATA, ctr<=N.
//   MPUT/MSTORE: TLAST -> err_pulse, IDLE; else -> WDATA.
//   MGET/MLOAD: TLAST -> RREQ; no TLAST -> err_pulse, DRAIN.
//  WDATA: cpu_req_valid=TVALID, we=1, data=TDATA, TREADY=cpu_req_ready (combinational pass-through, zero latency).
//   Beat on TVALID&cpu_req_ready: addr+=4, ctr-=1.
//   ctr==1 with TLAST: MPUT -> IDLE, MSTORE -> WAIT_RSP.
//   ctr==1 without TLAST -> err_pulse, DRAIN. TLAST with ctr>1 -> err_pulse, IDLE (partial writes stand).
//  RREQ: TREADY=0; cpu_req_valid=1, we=0; each cpu_req_ready: addr+=4, ctr-=1; last accept -> WAIT_RSP.
//  WAIT_RSP: TREADY=0; hold header1/data1; rsp_done -> IDLE. rsp_done in other states ignored.
//  DRAIN: TREADY=1, discard; TVALID&TLAST -> IDLE.
//  header1/data1 change only on IDLE/ADDR accepts; stable from ADDR exit until IDLE re-entry.
//  Reset mid-packet: immediate IDLE; remaining words of that packet fail dest/code checks or are drained by later errors; no recovery beyond this.
//  cpu_req_valid never deasserts without cpu_req_ready in RREQ; in WDATA it follows TVALID.
// STRUCTURE
//  Package mem_mgr_noc_pkg: opcode localparams (MACK 1, MDATA 2, MPUT..MSTORE 4..7), header field bit positions, dec_state_t enum {IDLE,ADDR,WDATA,RREQ,WAIT_RSP,DRAIN}.
//  Shared by encoder and decoder.
//  Sub-module mem_mgr_noc_hdr_check (combinational): header -> code, long, len, dest_ok, code_ok, len_ok.
//  Rest: one FSM + addr/ctr registers.
// TESTING
//  MPUT short {hdr code4, dest=HsrcId}, addr 0x100, data 0xA5A5 TLAST -> one write @0x100 data 0xA5A5, back to IDLE, no WAIT_RSP.
//  MSTORE long len=2 (4 words) addr 0x40, cpu_req_ready toggling -> writes 0x40,0x44,0x48,0x4C in order; WAIT_RSP until rsp_done.
//  MGET long len=3, addr 0x200 TLAST -> 8 reads 0x200..0x21C, header1/data1 stable until rsp_done pulse.
//  MLOAD short, dest X mismatch (3-word packet) -> err_pulse once, all words drained, no cpu_req_valid.
//  MPUT long len=1 with TLAST on first data word -> one write, err_pulse, IDLE; next packet decodes correctly.
//  Reset asserted in WDATA mid-burst -> outputs 0 asynchronously; after release IDLE, TREADY=1.

Source files
------------

// File: rtl/mem_mgr_noc_pkg.sv
// rtl/mem_mgr_noc_pkg.sv - shared NoC opcodes, header field positions and decoder states
package mem_mgr_noc_pkg;

    localparam logic [2:0] MACK   = 3'd1;
    localparam logic [2:0] MDATA  = 3'd2;
    localparam logic [2:0] MPUT   = 3'd4;
    localparam logic [2:0] MGET   = 3'd5;
    localparam logic [2:0] MLOAD  = 3'd6;
    localparam logic [2:0] MSTORE = 3'd7;

    localparam int HDR_LONG_BIT = 28;
    localparam int HDR_CODE_LSB = 25;
    localparam int HDR_PT_BIT   = 24;
    localparam int HDR_SRCY_LSB = 21;
    localparam int HDR_SRCX_LSB = 18;
    localparam int HDR_OFS_LSB  = 6;
    localparam int HDR_LEN_LSB  = 12;
    localparam int HDR_DSTY_LSB = 3;
    localparam int HDR_DSTX_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        RREQ,
        WAIT_RSP,
        DRAIN
    } dec_state_t;

    // Short packets move one word; long packets move 2^len words.
    function automatic logic [16:0] word_count(input logic is_long, input logic [3:0] len);
        return is_long ? (17'd1 << len) : 17'd1;
    endfunction

endpackage

// File: rtl/mem_mgr_noc_hdr_check.sv
// rtl/mem_mgr_noc_hdr_check.sv - combinational header field extraction and validity checks
module mem_mgr_noc_hdr_check
    import mem_mgr_noc_pkg::*;
#(
    parameter int XY_SZ        = 3,
    parameter int MAX_LEN_LOG2 = 8
) (
    input  logic [31:0]        hdr,
    input  logic [2*XY_SZ-1:0] own_id,
    output logic [2:0]         code,
    output logic               is_long,
    output logic [3:0]         len,
    output logic               dest_ok,
    output logic               code_ok,
    output logic               len_ok
);

    logic unused_hdr_bits;
    assign unused_hdr_bits = ^{hdr[31:29], hdr[24:16], hdr[11:6]};

    assign code    = hdr[HDR_CODE_LSB +: 3];
    assign is_long = hdr[HDR_LONG_BIT];
    assign len     = hdr[HDR_LEN_LSB +: 4];
    assign dest_ok = ({hdr[HDR_DSTY_LSB +: XY_SZ], hdr[HDR_DSTX_LSB +: XY_SZ]} == own_id);
    assign code_ok = (code == MPUT) || (code == MGET) || (code == MLOAD) || (code == MSTORE);
    assign len_ok  = !is_long || (int'(len) <= MAX_LEN_LOG2);

endmodule

// File: rtl/mem_mgr_noc_decoder.sv
// rtl/mem_mgr_noc_decoder.sv - inbound NoC packet parser issuing CPU-bus word requests
module mem_mgr_noc_decoder
    import mem_mgr_noc_pkg::*;
#(
    parameter int XY_SZ        = 3,
    parameter int MAX_LEN_LOG2 = 8
) (
    input  logic               clk_ctrl,
    input  logic               clk_ctrl_rst_low,
    input  logic [2*XY_SZ-1:0] HsrcId,
    input  logic               stream_in_TVALID,
    input  logic [31:0]        stream_in_TDATA,
    input  logic [3:0]         stream_in_TKEEP,
    input  logic               stream_in_TLAST,
    output logic               stream_in_TREADY,
    output logic               cpu_req_valid,
    output logic               cpu_req_we,
    output logic [31:0]        cpu_req_addr,
    output logic [31:0]        cpu_req_data,
    input  logic               cpu_req_ready,
    output logic [31:0]        header1,
    output logic [31:0]        data1,
    input  logic               rsp_done,
    output logic               busy,
    output logic               err_pulse
);

    dec_state_t  state;
    logic        running;
    logic [31:0] addr_q;
    logic [16:0] ctr;

    logic [2:0]  in_code;
    logic        in_long;
    logic [3:0]  in_len;
    logic        dest_ok, code_ok, len_ok;

    logic unused_keep;
    assign unused_keep = ^stream_in_TKEEP;

    mem_mgr_noc_hdr_check #(
        .XY_SZ        (XY_SZ),
        .MAX_LEN_LOG2 (MAX_LEN_LOG2)
    ) u_hdr_check (
        .hdr     (stream_in_TDATA),
        .own_id  (HsrcId),
        .code    (in_code),
        .is_long (in_long),
        .len     (in_len),
        .dest_ok (dest_ok),
        .code_ok (code_ok),
        .len_ok  (len_ok)
    );

    logic unused_in_fields;
    assign unused_in_fields = ^{in_code, in_long, in_len};

    logic [2:0] cur_code;
    logic       cur_is_write;
    assign cur_code     = header1[HDR_CODE_LSB +: 3];
    assign cur_is_write = (cur_code == MPUT) || (cur_code == MSTORE);

    logic accept;
    assign accept = stream_in_TVALID && stream_in_TREADY;

    // Write data passes straight through to the CPU bus; running keeps TREADY low while in reset.
    always_comb begin
        stream_in_TREADY = 1'b0;
        cpu_req_valid    = 1'b0;
        cpu_req_we       = 1'b0;
        cpu_req_data     = 32'd0;
        if (running) begin
            case (state)
                IDLE, ADDR, DRAIN: stream_in_TREADY = 1'b1;
                WDATA: begin
                    stream_in_TREADY = cpu_req_ready;
                    cpu_req_valid    = stream_in_TVALID;
                    cpu_req_we       = 1'b1;
                    cpu_req_data     = stream_in_TDATA;
                end
                RREQ:    cpu_req_valid = 1'b1;
                default: ;
            endcase
        end
    end

    assign cpu_req_addr = addr_q;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk_ctrl or negedge clk_ctrl_rst_low) begin
        if (!clk_ctrl_rst_low) begin
            state     <= IDLE;
            running   <= 1'b0;
            header1   <= 32'd0;
            data1     <= 32'd0;
            addr_q    <= 32'd0;
            ctr       <= 17'd0;
            err_pulse <= 1'b0;
        end else begin
            running   <= 1'b1;
            err_pulse <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    header1 <= stream_in_TDATA;
                    if (!(dest_ok && code_ok && len_ok)) begin
                        err_pulse <= 1'b1;
                        state     <= stream_in_TLAST ? IDLE : DRAIN;
                    end else if (stream_in_TLAST) begin
                        err_pulse <= 1'b1;
                    end else begin
                        state <= ADDR;
                    end
                end
                ADDR: if (accept) begin
                    data1  <= stream_in_TDATA;
                    addr_q <= stream_in_TDATA;
                    ctr    <= word_count(header1[HDR_LONG_BIT], header1[HDR_LEN_LSB +: 4]);
                    if (cur_is_write) begin
                        if (stream_in_TLAST) begin
                            err_pulse <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state <= WDATA;
                        end
                    end else if (stream_in_TLAST) begin
                        state <= RREQ;
                    end else begin
                        err_pulse <= 1'b1;
                        state     <= DRAIN;
                    end
                end
                WDATA: if (stream_in_TVALID && cpu_req_ready) begin
                    addr_q <= addr_q + 32'd4;
                    ctr    <= ctr - 17'd1;
                    if (ctr == 17'd1) begin
                        if (stream_in_TLAST) begin
                            state <= (cur_code == MSTORE) ? WAIT_RSP : IDLE;
                        end else begin
                            err_pulse <= 1'b1;
                            state     <= DRAIN;
                        end
                    end else if (stream_in_TLAST) begin
                        err_pulse <= 1'b1;
                        state     <= IDLE;
                    end
                end
                RREQ: if (cpu_req_ready) begin
                    addr_q <= addr_q + 32'd4;
                    ctr    <= ctr - 17'd1;
                    if (ctr == 17'd1) state <= WAIT_RSP;
                end
                WAIT_RSP: if (rsp_done) state <= IDLE;
                DRAIN:    if (stream_in_TVALID && stream_in_TLAST) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_mgr_noc_decoder.sv
// tb/tb_mem_mgr_noc_decoder.sv - directed self-checking bench for mem_mgr_noc_decoder
module tb_mem_mgr_noc_decoder;

    logic        clk_ctrl = 1'b0;
    logic        clk_ctrl_rst_low;
    logic [5:0]  HsrcId;
    logic        tvalid, tlast, tready;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        req_valid, req_we, req_ready;
    logic [31:0] req_addr, req_data;
    logic [31:0] header1, data1;
    logic        rsp_done, busy, err_pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk_ctrl = ~clk_ctrl;

    mem_mgr_noc_decoder #(.XY_SZ(3), .MAX_LEN_LOG2(8)) dut (
        .clk_ctrl         (clk_ctrl),
        .clk_ctrl_rst_low (clk_ctrl_rst_low),
        .HsrcId           (HsrcId),
        .stream_in_TVALID (tvalid),
        .stream_in_TDATA  (tdata),
        .stream_in_TKEEP  (tkeep),
        .stream_in_TLAST  (tlast),
        .stream_in_TREADY (tready),
        .cpu_req_valid    (req_valid),
        .cpu_req_we       (req_we),
        .cpu_req_addr     (req_addr),
        .cpu_req_data     (req_data),
        .cpu_req_ready    (req_ready),
        .header1          (header1),
        .data1            (data1),
        .rsp_done         (rsp_done),
        .busy             (busy),
        .err_pulse        (err_pulse)
    );

    function automatic logic [31:0] mk_hdr(input logic lng, input logic [2:0] code,
                                           input logic [3:0] len, input logic [2:0] dy,
                                           input logic [2:0] dx);
        return {3'b000, lng, code, 9'd0, len, 6'd0, dy, dx};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic r);
        @(negedge clk_ctrl);
        tvalid    = v;
        tdata     = d;
        tlast     = l;
        req_ready = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_ctrl);
        #1;
    endtask

    task automatic pulse_rsp();
        @(negedge clk_ctrl);
        rsp_done = 1'b1;
        tick();
        @(negedge clk_ctrl);
        rsp_done = 1'b0;
        #1;
    endtask

    logic [31:0] h;

    initial begin
        clk_ctrl_rst_low = 1'b0;
        HsrcId    = 6'b010_101;
        tvalid    = 1'b0;
        tdata     = 32'd0;
        tlast     = 1'b0;
        tkeep     = 4'hF;
        req_ready = 1'b0;
        rsp_done  = 1'b0;

        repeat (2) tick();
        chk("rst_tready", tready, 0);
        chk("rst_valid", req_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_pulse, 0);
        chk("rst_header1", header1, 0);
        chk("rst_data1", data1, 0);
        @(negedge clk_ctrl);
        clk_ctrl_rst_low = 1'b1;
        drive(0, 0, 0, 0);
        chk("idle_tready", tready, 1);

        // MPUT short: single write, straight back to IDLE
        h = mk_hdr(0, 3'd4, 4'd0, 3'd2, 3'd5);
        drive(1, h, 0, 0);
        tick();
        chk("mput_header1", header1, h);
        chk("mput_busy_addr", busy, 1);
        drive(1, 32'h100, 0, 0);
        tick();
        chk("mput_data1", data1, 32'h100);
        drive(1, 32'hA5A5, 1, 1);
        chk("mput_valid", req_valid, 1);
        chk("mput_we", req_we, 1);
        chk("mput_addr", req_addr, 32'h100);
        chk("mput_data", req_data, 32'hA5A5);
        chk("mput_tready", tready, 1);
        tick();
        chk("mput_idle", busy, 0);
        chk("mput_no_err", err_pulse, 0);

        // MSTORE long len=2 with toggling ready
        h = mk_hdr(1, 3'd7, 4'd2, 3'd2, 3'd5);
        drive(1, h, 0, 0);
        tick();
        drive(1, 32'h40, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h1000 + i, i == 3, 0);
            chk($sformatf("mst_stall_valid%0d", i), req_valid, 1);
            chk($sformatf("mst_stall_tready%0d", i), tready, 0);
            tick();
            drive(1, 32'h1000 + i, i == 3, 1);
            chk($sformatf("mst_addr%0d", i), req_addr, 32'h40 + 4 * i);
            chk($sformatf("mst_data%0d", i), req_data, 32'h1000 + i);
            tick();
        end
        drive(0, 0, 0, 0);
        chk("mst_wait_busy", busy, 1);
        chk("mst_wait_tready", tready, 0);
        tick();
        tick();
        chk("mst_hold_header1", header1, h);
        chk("mst_hold_data1", data1, 32'h40);
        chk("mst_still_wait", busy, 1);
        pulse_rsp();
        chk("mst_done_idle", busy, 0);

        // MGET long len=3: eight reads with stable header1/data1
        h = mk_hdr(1, 3'd5, 4'd3, 3'd2, 3'd5);
        drive(1, h, 0, 0);
        tick();
        drive(1, 32'h200, 1, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0);
            chk($sformatf("mget_valid%0d", i), req_valid, 1);
            chk($sformatf("mget_we%0d", i), req_we, 0);
            chk($sformatf("mget_tready%0d", i), tready, 0);
            tick();
            drive(0, 0, 0, 1);
            chk($sformatf("mget_addr%0d", i), req_addr, 32'h200 + 4 * i);
            tick();
        end
        drive(0, 0, 0, 0);
        chk("mget_wait_valid", req_valid, 0);
        chk("mget_wait_busy", busy, 1);
        chk("mget_hold_header1", header1, h);
        chk("mget_hold_data1", data1, 32'h200);
        pulse_rsp();
        chk("mget_done_idle", busy, 0);

        // MLOAD short to wrong X: one error, whole packet drained
        h = mk_hdr(0, 3'd6, 4'd0, 3'd2, 3'd4);
        drive(1, h, 0, 0);
        chk("mld_valid0", req_valid, 0);
        tick();
        chk("mld_err", err_pulse, 1);
        chk("mld_drain_busy", busy, 1);
        drive(1, 32'h123, 0, 0);
        chk("mld_valid1", req_valid, 0);
        chk("mld_drain_tready", tready, 1);
        tick();
        chk("mld_err_once", err_pulse, 0);
        drive(1, 32'h456, 1, 0);
        chk("mld_valid2", req_valid, 0);
        tick();
        chk("mld_idle", busy, 0);
        chk("mld_no_err2", err_pulse, 0);

        // Long length above the limit with TLAST on header
        h = mk_hdr(1, 3'd4, 4'd9, 3'd2, 3'd5);
        drive(1, h, 1, 0);
        tick();
        chk("len9_err", err_pulse, 1);
        chk("len9_idle", busy, 0);

        // MPUT long len=1 ending early, then a clean packet
        h = mk_hdr(1, 3'd4, 4'd1, 3'd2, 3'd5);
        drive(1, h, 0, 0);
        tick();
        drive(1, 32'h300, 0, 0);
        tick();
        drive(1, 32'hBEEF, 1, 1);
        chk("early_valid", req_valid, 1);
        chk("early_addr", req_addr, 32'h300);
        tick();
        chk("early_err", err_pulse, 1);
        chk("early_idle", busy, 0);
        h = mk_hdr(0, 3'd4, 4'd0, 3'd2, 3'd5);
        drive(1, h, 0, 0);
        tick();
        chk("next_addr_state", busy, 1);
        drive(1, 32'h310, 0, 0);
        tick();
        drive(1, 32'h77, 1, 1);
        chk("next_addr", req_addr, 32'h310);
        chk("next_data", req_data, 32'h77);
        tick();
        chk("next_idle", busy, 0);
        chk("next_no_err", err_pulse, 0);

        // Asynchronous reset in the middle of a write burst
        h = mk_hdr(1, 3'd4, 4'd2, 3'd2, 3'd5);
        drive(1, h, 0, 0);
        tick();
        drive(1, 32'h500, 0, 0);
        tick();
        drive(1, 32'h1, 0, 1);
        tick();
        drive(1, 32'h2, 0, 1);
        chk("mid_addr", req_addr, 32'h504);
        chk("mid_valid", req_valid, 1);
        clk_ctrl_rst_low = 1'b0;
        #1;
        chk("arst_valid", req_valid, 0);
        chk("arst_tready", tready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_header1", header1, 0);
        chk("arst_addr", req_addr, 0);
        drive(0, 0, 0, 0);
        clk_ctrl_rst_low = 1'b1;
        drive(0, 0, 0, 0);
        chk("post_rst_tready", tready, 1);
        chk("post_rst_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
